// File: rtl/hazard_ctrl_pkg.sv
// Shared sizing constants and types for the decode-stage hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_IDX_WIDTH = 5;
  localparam int HAZ_NUM_REGS  = 32;
  localparam int HAZ_CNT_W     = 2;
  localparam int HAZ_TIMEOUT   = 1024;
  localparam int STALL_CNT_W   = 32;

  // Individual hazard causes for the instruction sitting in decode.
  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw;
  } haz_terms_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode / ID_EX / writeback / squash signals seen by the hazard controller.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int IDX_W = REG_IDX_WIDTH
);

  logic             dec_valid_i;
  logic [IDX_W-1:0] dec_rs1_idx_i;
  logic [IDX_W-1:0] dec_rs2_idx_i;
  logic             dec_rs1_en_i;
  logic             dec_rs2_en_i;
  logic [IDX_W-1:0] dec_rd_idx_i;
  logic             dec_rd_en_i;
  logic             idex_ready_i;
  logic             flush_i;
  logic             wb_valid_i;
  logic [IDX_W-1:0] wb_rd_idx_i;
  logic             kill_valid_i;
  logic [IDX_W-1:0] kill_rd_idx_i;
  logic             issue_o;
  logic             stall_o;
  logic [31:0]      stall_cnt_o;
  logic             timeout_o;
  logic             err_o;

  // Pipeline side: presents decode/writeback/squash, observes issue/stall.
  modport master (
    output dec_valid_i, dec_rs1_idx_i, dec_rs2_idx_i, dec_rs1_en_i, dec_rs2_en_i,
           dec_rd_idx_i, dec_rd_en_i, idex_ready_i, flush_i,
           wb_valid_i, wb_rd_idx_i, kill_valid_i, kill_rd_idx_i,
    input  issue_o, stall_o, stall_cnt_o, timeout_o, err_o
  );

  // Controller side.
  modport slave (
    input  dec_valid_i, dec_rs1_idx_i, dec_rs2_idx_i, dec_rs1_en_i, dec_rs2_en_i,
           dec_rd_idx_i, dec_rd_en_i, idex_ready_i, flush_i,
           wb_valid_i, wb_rd_idx_i, kill_valid_i, kill_rd_idx_i,
    output issue_o, stall_o, stall_cnt_o, timeout_o, err_o
  );

endinterface

// File: rtl/hazard_ctrl_sb_entry.sv
// One scoreboard entry: count of in-flight writes to a single register.
// Applies +inc -dec_a -dec_b in one cycle; a net result below zero clamps
// to zero and raises the combinational underflow pulse.
module hazard_ctrl_sb_entry
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = HAZ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] CNT_MAX_S = SW'((2 ** CNT_W) - 1);

  logic signed [SW-1:0] cnt_nxt;

  // Clamp a signed candidate count into the unsigned counter range.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [SW-1:0] v);
    if (v < 0)
      return '0;
    else if (v > CNT_MAX_S)
      return '1;
    else
      return v[CNT_W-1:0];
  endfunction

  // Net change for this cycle, in signed arithmetic so underflow is visible.
  always_comb begin
    cnt_nxt   = $signed({2'b00, cnt})
              + $signed({{(SW-1){1'b0}}, inc})
              - $signed({{(SW-1){1'b0}}, dec_a})
              - $signed({{(SW-1){1'b0}}, dec_b});
    underflow = (cnt_nxt < 0);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= sat_cnt(cnt_nxt);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue/stall controller. A per-register scoreboard of
// in-flight writes blocks RAW reads and writes that would overflow a
// register's counter; there is no forwarding, so every hazard is a stall.
// Also keeps a saturating stall-cycle counter and a stall watchdog.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = HAZ_NUM_REGS,
  parameter int IDX_W    = REG_IDX_WIDTH,
  parameter int CNT_W    = HAZ_CNT_W,
  parameter int TIMEOUT  = HAZ_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               RUN_W   = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(TIMEOUT);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            uflow;

  logic [CNT_W-1:0]       rs1_cnt, rs2_cnt, rd_cnt;
  haz_terms_t             terms;
  logic                   hazard;
  logic                   issue;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [RUN_W-1:0]       run_len;
  logic                   timeout;
  logic                   err;

  // Saturating increment for the stall statistics counter.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // x0 is hard-wired: never tracked, never underflows.
  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;

  // One scoreboard entry per architectural register other than x0.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic inc, dec_wb, dec_kill;
    assign inc      = issue & bus.dec_rd_en_i & (bus.dec_rd_idx_i == IDX_W'(r));
    assign dec_wb   = bus.wb_valid_i   & (bus.wb_rd_idx_i   == IDX_W'(r));
    assign dec_kill = bus.kill_valid_i & (bus.kill_rd_idx_i == IDX_W'(r));

    hazard_ctrl_sb_entry #(.CNT_W(CNT_W)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc),
      .dec_a     (dec_wb),
      .dec_b     (dec_kill),
      .cnt       (cnt[r]),
      .underflow (uflow[r])
    );
  end

  // Hazard detection from registered counts only: a release in the same
  // cycle does not unblock; the instruction issues the cycle after.
  always_comb begin
    rs1_cnt = (int'(bus.dec_rs1_idx_i) < NUM_REGS) ? cnt[bus.dec_rs1_idx_i] : '0;
    rs2_cnt = (int'(bus.dec_rs2_idx_i) < NUM_REGS) ? cnt[bus.dec_rs2_idx_i] : '0;
    rd_cnt  = (int'(bus.dec_rd_idx_i)  < NUM_REGS) ? cnt[bus.dec_rd_idx_i]  : '0;

    terms.raw1 = bus.dec_rs1_en_i & (bus.dec_rs1_idx_i != '0) & (rs1_cnt != '0);
    terms.raw2 = bus.dec_rs2_en_i & (bus.dec_rs2_idx_i != '0) & (rs2_cnt != '0);
    terms.waw  = bus.dec_rd_en_i  & (bus.dec_rd_idx_i  != '0) & (rd_cnt == CNT_MAX);
    hazard     = terms.raw1 | terms.raw2 | terms.waw;

    issue = bus.dec_valid_i & ~bus.flush_i & ~hazard & bus.idex_ready_i;
    stall = bus.dec_valid_i & ~bus.flush_i & (hazard | ~bus.idex_ready_i);
  end

  // Stall statistics, watchdog and sticky scoreboard error.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      run_len   <= '0;
      timeout   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
        if (run_len != RUN_SAT)
          run_len <= run_len + 1'b1;
        if (run_len == RUN_LAST)
          timeout <= 1'b1;
      end else begin
        run_len <= '0;
      end
      if (|uflow)
        err <= 1'b1;
    end
  end

  assign bus.issue_o     = issue;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.timeout_o   = timeout;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW stall/release, WAW overflow stall,
// double release underflow, x0 handling, flush/backpressure, watchdog, reset.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.IDX_W(5)) bus ();

  hazard_ctrl #(
    .NUM_REGS (32),
    .IDX_W    (5),
    .CNT_W    (2),
    .TIMEOUT  (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid_i   = 1'b0;
    bus.dec_rs1_idx_i = '0;
    bus.dec_rs2_idx_i = '0;
    bus.dec_rs1_en_i  = 1'b0;
    bus.dec_rs2_en_i  = 1'b0;
    bus.dec_rd_idx_i  = '0;
    bus.dec_rd_en_i   = 1'b0;
    bus.idex_ready_i  = 1'b1;
    bus.flush_i       = 1'b0;
    bus.wb_valid_i    = 1'b0;
    bus.wb_rd_idx_i   = '0;
    bus.kill_valid_i  = 1'b0;
    bus.kill_rd_idx_i = '0;
  endtask

  task automatic dec(input int rs1, input bit e1, input int rs2, input bit e2,
                     input int rd, input bit erd);
    bus.dec_valid_i   = 1'b1;
    bus.dec_rs1_idx_i = 5'(rs1);
    bus.dec_rs1_en_i  = e1;
    bus.dec_rs2_idx_i = 5'(rs2);
    bus.dec_rs2_en_i  = e2;
    bus.dec_rd_idx_i  = 5'(rd);
    bus.dec_rd_en_i   = erd;
  endtask

  task automatic wb(input int rd);
    bus.wb_valid_i  = 1'b1;
    bus.wb_rd_idx_i = 5'(rd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_issue",     32'(bus.issue_o),   0);
    chk("reset_stall",     32'(bus.stall_o),   0);
    chk("reset_stall_cnt", bus.stall_cnt_o,    0);
    chk("reset_timeout",   32'(bus.timeout_o), 0);
    chk("reset_err",       32'(bus.err_o),     0);

    // RAW on x5: stall until the cycle after writeback.
    dec(0, 0, 0, 0, 5, 1); #1;
    chk("t1_addi_issue", 32'(bus.issue_o), 1);
    chk("t1_addi_stall", 32'(bus.stall_o), 0);
    tick();
    dec(5, 1, 1, 1, 6, 1); #1;
    chk("t1_raw_stall", 32'(bus.stall_o), 1);
    chk("t1_raw_issue", 32'(bus.issue_o), 0);
    tick();
    wb(5); #1;
    chk("t1_wb_same_cycle_stall", 32'(bus.stall_o), 1);
    chk("t1_wb_same_cycle_issue", 32'(bus.issue_o), 0);
    tick();
    bus.wb_valid_i = 1'b0; #1;
    chk("t1_after_wb_issue", 32'(bus.issue_o), 1);
    chk("t1_after_wb_stall", 32'(bus.stall_o), 0);
    tick();
    chk("t1_stall_cnt", bus.stall_cnt_o, 2);
    idle(); wb(6); tick(); idle();

    // WAW overflow on x7: three in flight block a fourth.
    for (int i = 0; i < 3; i++) begin
      dec(0, 0, 0, 0, 7, 1); #1;
      chk("t2_x7_issue", 32'(bus.issue_o), 1);
      tick();
    end
    dec(0, 0, 0, 0, 7, 1); #1;
    chk("t2_waw_stall", 32'(bus.stall_o), 1);
    chk("t2_waw_issue", 32'(bus.issue_o), 0);
    tick();
    wb(7); #1;
    chk("t2_waw_wb_same_cycle", 32'(bus.stall_o), 1);
    tick();
    bus.wb_valid_i = 1'b0; #1;
    chk("t2_waw_release_issue", 32'(bus.issue_o), 1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      wb(7); tick();
    end
    idle(); #1;
    chk("t2_stall_cnt", bus.stall_cnt_o, 4);

    // Double release on x9 with only one write in flight.
    dec(0, 0, 0, 0, 9, 1); tick();
    idle(); #1;
    chk("t3_err_before", 32'(bus.err_o), 0);
    wb(9);
    bus.kill_valid_i  = 1'b1;
    bus.kill_rd_idx_i = 5'd9;
    tick();
    idle(); #1;
    chk("t3_err_after", 32'(bus.err_o), 1);
    dec(9, 1, 0, 0, 0, 0); #1;
    chk("t3_x9_cleared_issue", 32'(bus.issue_o), 1);
    tick();

    // x0 is never tracked.
    for (int i = 0; i < 5; i++) begin
      dec(0, 1, 0, 0, 0, 1); #1;
      chk("t4_x0_issue", 32'(bus.issue_o), 1);
      chk("t4_x0_stall", 32'(bus.stall_o), 0);
      tick();
    end
    dec(0, 1, 0, 1, 0, 0); #1;
    chk("t4_x0_reader_issue", 32'(bus.issue_o), 1);
    tick();
    dec(5, 1, 7, 1, 9, 1); #1;
    chk("t4_clean_regs_issue", 32'(bus.issue_o), 1);
    tick();
    idle(); wb(9); tick(); idle();

    // Flush masks a hazard; backpressure stalls and is counted.
    dec(0, 0, 0, 0, 10, 1); tick();
    dec(10, 1, 0, 0, 0, 0);
    bus.flush_i = 1'b1; #1;
    chk("t5_flush_issue", 32'(bus.issue_o), 0);
    chk("t5_flush_stall", 32'(bus.stall_o), 0);
    tick();
    chk("t5_flush_stall_cnt", bus.stall_cnt_o, 4);
    bus.flush_i = 1'b0;
    dec(0, 0, 0, 0, 11, 1);
    bus.idex_ready_i = 1'b0; #1;
    chk("t5_notready_stall", 32'(bus.stall_o), 1);
    chk("t5_notready_issue", 32'(bus.issue_o), 0);
    tick();
    chk("t5_stall_cnt_a", bus.stall_cnt_o, 5);
    tick();
    chk("t5_stall_cnt_b", bus.stall_cnt_o, 6);
    bus.idex_ready_i = 1'b1;
    dec(10, 1, 0, 0, 0, 0); #1;
    chk("t5_x10_still_busy", 32'(bus.stall_o), 1);
    tick();
    idle(); wb(10); tick(); idle(); #1;
    chk("t5_stall_cnt_c", bus.stall_cnt_o, 7);

    // Watchdog: 1024 consecutive RAW stall cycles after a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0;
    dec(0, 0, 0, 0, 5, 1); tick();
    dec(5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 1023; i++) tick();
    chk("t6_timeout_early", 32'(bus.timeout_o), 0);
    chk("t6_stall_cnt_1023", bus.stall_cnt_o, 1023);
    tick();
    chk("t6_timeout_set", 32'(bus.timeout_o), 1);
    chk("t6_stall_cnt_1024", bus.stall_cnt_o, 1024);
    tick();
    chk("t6_timeout_sticky", 32'(bus.timeout_o), 1);
    idle();
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("t6_rst_timeout",   32'(bus.timeout_o), 0);
    chk("t6_rst_stall_cnt", bus.stall_cnt_o,    0);
    chk("t6_rst_err",       32'(bus.err_o),     0);
    chk("t6_rst_stall",     32'(bus.stall_o),   0);
    dec(5, 1, 0, 0, 6, 1); #1;
    chk("t6_post_rst_issue", 32'(bus.issue_o), 1);
    chk("t6_post_rst_stall", 32'(bus.stall_o), 0);
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Issue/stall controller for the decode stage.
- Keeps a per-register scoreboard of in-flight writes. Combines it with decode's rs1/rs2/rd indices and enables to decide each cycle whether the decoded instruction issues into ID_EX or holds IF_ID.
- Releases scoreboard entries on writeback and on squash. No forwarding: RAW and WAW-overflow hazards are resolved by stalling.
- Also keeps a stall-cycle counter and a stall watchdog.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- IDX_W, 5, register index width (= `REG_IDX_WIDTH).
- CNT_W, 2, per-register in-flight counter width; max outstanding writes per register = 2^CNT_W-1.
- TIMEOUT, 1024, consecutive stall cycles before the watchdog fires.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- dec_valid_i  in  1  decode holds a valid instruction
- dec_rs1_idx_i  in  IDX_W  rs1 index from decode
- dec_rs2_idx_i  in  IDX_W  rs2 index from decode
- dec_rs1_en_i  in  1  instruction reads rs1
- dec_rs2_en_i  in  1  instruction reads rs2
- dec_rd_idx_i  in  IDX_W  rd index from decode
- dec_rd_en_i  in  1  instruction writes rd
- idex_ready_i  in  1  ID_EX can accept an instruction
- flush_i  in  1  redirect this cycle; the decode instruction is discarded
- wb_valid_i  in  1  a write to wb_rd_idx_i retires this cycle
- wb_rd_idx_i  in  IDX_W  retiring rd
- kill_valid_i  in  1  an issued writer was squashed and will never write back
- kill_rd_idx_i  in  IDX_W  squashed rd
- issue_o  out  1  decode instruction enters ID_EX this cycle
- stall_o  out  1  hold PC and IF_ID this cycle
- stall_cnt_o  out  32  saturating count of stall cycles
- timeout_o  out  1  sticky; TIMEOUT consecutive stall cycles reached
- err_o  out  1  sticky; release issued to a counter already at 0

Behaviour:
Reset:
- All counters = 0; stall_cnt_o = 0; timeout_o = 0; err_o = 0; internal run-length = 0.
- issue_o and stall_o are combinational and read 0 while dec_valid_i = 0.

Hazard terms (combinational, from registered counters only):
- raw1 = rs1_en & rs1 != 0 & cnt[rs1] != 0; raw2 likewise for rs2.
- waw = rd_en & rd != 0 & cnt[rd] == 2^CNT_W-1.
- A release arriving in the same cycle does NOT clear the hazard; the instruction issues one cycle later.
- hazard = raw1 | raw2 | waw.

Outputs:
- issue_o = dec_valid_i & ~flush_i & ~hazard & idex_ready_i.
- stall_o = dec_valid_i & ~flush_i & (hazard | ~idex_ready_i).
- flush_i forces both outputs to 0.

Counter update (per register r ≠ 0, next cycle):
- cnt[r] += inc − dec_wb − dec_kill.
- inc = issue_o & rd_en & rd == r.
- dec_wb = wb_valid_i & wb_rd == r; dec_kill likewise for the kill port.
- Simultaneous inc and dec on the same r: net applied in one cycle.
- wb and kill on the same r: decrement by 2.
- Underflow (decrement request exceeding cnt): clamp to 0 and set err_o.
- Releases to index 0 are ignored silently.
- inc can never overflow, because waw blocks issue at max.

Stall statistics:
- stall_cnt_o increments every cycle stall_o = 1 and saturates at 0xFFFF_FFFF.
- Run-length counter increments while stall_o = 1 and clears when stall_o = 0.
- When run-length reaches TIMEOUT, timeout_o is set and held until rst.

Reset mid-operation: all scoreboard state is dropped. The pipeline is flushed by the same reset, so no pending writebacks survive it.

Decomposition:
- Shared defines file gets:
  - HAZ_CNT_W
  - HAZ_TIMEOUT default
  - `REG_IDX_WIDTH / NUM_REGS reuse
- One natural sub-module, sb_entry: a single saturating up/down counter with inc, dec_a, dec_b, underflow flag. Instantiated via generate for r = 1..NUM_REGS-1.
- Hazard logic, issue/stall logic and statistics live in hazard_ctrl.

Test Plan:
1. Issue `addi x5` (rd_en, rd = 5) with ready = 1. Next cycle decode `add x6, x5, x1` → stall_o = 1, issue_o = 0. Assert wb_valid_i with rd = 5 → still stalled that cycle. Next cycle issue_o = 1, stall_o = 0.
2. Three back-to-back issues writing x7 → cnt[7] = 3. A fourth writer of x7 with no RAW → stall_o = 1 (waw). One wb on x7 → fourth issues the following cycle.
3. cnt[9] = 1. wb_valid_i and kill_valid_i both target x9 in the same cycle → cnt[9] = 0 and err_o = 1.
4. rs1 = 0 and rd = 0 with rd_en = 1, issued 5 times → issue_o = 1 every cycle, no stall, all counters stay 0.
5. Hazard present and flush_i = 1 → issue_o = 0, stall_o = 0, counters unchanged. Hazard with idex_ready_i = 0 → stall_o = 1 and stall_cnt_o increments by 1 per cycle.
6. Hold a RAW stall for 1024 cycles → timeout_o rises on cycle 1024 and stall_cnt_o = 1024. rst → all outputs 0, and a following dependent instruction issues immediately.
